// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_PRESSED  = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  function automatic int key_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Hex legend of the 4x4 front panel, indexed by col_idx*4 + row_idx.
  function automatic logic [3:0] key_legend(input logic [3:0] code);
    logic [3:0] leg;
    case (code)
      4'd0:    leg = 4'h1;
      4'd1:    leg = 4'h4;
      4'd2:    leg = 4'h7;
      4'd3:    leg = 4'hE;
      4'd4:    leg = 4'h2;
      4'd5:    leg = 4'h5;
      4'd6:    leg = 4'h8;
      4'd7:    leg = 4'h0;
      4'd8:    leg = 4'h3;
      4'd9:    leg = 4'h6;
      4'd10:   leg = 4'h9;
      4'd11:   leg = 4'hF;
      4'd12:   leg = 4'hA;
      4'd13:   leg = 4'hB;
      4'd14:   leg = 4'hC;
      default: leg = 4'hD;
    endcase
    return leg;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-tick prescaler: one-cycle tick every TICK_DIV clocks.
module keypad_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: column strobing, press/release debounce, multi-key
// rejection, auto-repeat and a valid/ready event holding register.
//
// state       | meaning
// ST_IDLE     | all columns low, waiting for any row to go low
// ST_SCAN     | one column low per tick, looking for the pressed key
// ST_DEBOUNCE | column held, counting stable single-row ticks
// ST_PRESSED  | key accepted, counting hold ticks for auto-repeat
// ST_RELEASE  | all columns low, waiting for rows idle for DEBOUNCE ticks
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE    = 4,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  localparam int KW = key_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_rep,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_down,
  output logic            multi_err,
  output logic            overrun
);

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW    = $clog2(DEBOUNCE + 1);
  localparam int RPMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int PW    = (RPMAX > 0) ? $clog2(RPMAX + 1) : 1;

  localparam logic [ROWS-1:0] ALL_HI   = '1;
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [DW-1:0]   DEB_LD   = DW'(DEBOUNCE);
  localparam logic [PW-1:0]   DLY_LD   = PW'(REPEAT_DLY);
  localparam logic [PW-1:0]   RATE_LD  = PW'(REPEAT_RATE);

  logic            tick;
  logic [ROWS-1:0] row_meta, row_sync;
  int              n_low;
  logic [RW-1:0]   low_idx;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [ROWS-1:0] row_pat_q, row_pat_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [PW-1:0]   rep_q, rep_d;
  logic            ev_fire, ev_rep, multi_hit;
  logic [KW-1:0]   ev_code;

  keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Rows idle high, so the synchronizer resets to the released pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_comb begin
    n_low   = 0;
    low_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!row_sync[i]) begin
        n_low   = n_low + 1;
        low_idx = RW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_idx_q <= '0;
      row_pat_q <= '1;
      row_idx_q <= '0;
      deb_q     <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_pat_q <= row_pat_d;
      row_idx_q <= row_idx_d;
      deb_q     <= deb_d;
      rep_q     <= rep_d;
    end
  end

  // deb_q and rep_q count down the ticks still needed; a zero repeat
  // counter stays at zero, which is how REPEAT_DLY/RATE = 0 disable repeat.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_pat_d = row_pat_q;
    row_idx_d = row_idx_q;
    deb_d     = deb_q;
    rep_d     = rep_q;
    ev_fire   = 1'b0;
    ev_rep    = 1'b0;
    multi_hit = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (row_sync != ALL_HI) begin
            state_d   = ST_SCAN;
            col_idx_d = '0;
          end
        end
        ST_SCAN: begin
          if (n_low == 1) begin
            row_pat_d = row_sync;
            row_idx_d = low_idx;
            deb_d     = DEB_LD - DW'(1);
            state_d   = ST_DEBOUNCE;
          end else if (n_low > 1) begin
            multi_hit = 1'b1;
            deb_d     = DEB_LD;
            state_d   = ST_RELEASE;
          end else if (col_idx_q == COL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            col_idx_d = col_idx_q + CW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (row_sync == row_pat_q) begin
            if (deb_q <= DW'(1)) begin
              ev_fire = 1'b1;
              rep_d   = DLY_LD;
              state_d = ST_PRESSED;
            end else begin
              deb_d = deb_q - DW'(1);
            end
          end else begin
            multi_hit = (n_low > 1);
            deb_d     = DEB_LD;
            state_d   = ST_RELEASE;
          end
        end
        ST_PRESSED: begin
          if (row_sync == row_pat_q) begin
            if (rep_q == PW'(1)) begin
              ev_fire = 1'b1;
              ev_rep  = 1'b1;
              rep_d   = RATE_LD;
            end else if (rep_q != '0) begin
              rep_d = rep_q - PW'(1);
            end
          end else begin
            deb_d   = DEB_LD;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row_sync == ALL_HI) begin
            if (deb_q <= DW'(1)) begin
              state_d = ST_IDLE;
            end else begin
              deb_d = deb_q - DW'(1);
            end
          end else begin
            deb_d = DEB_LD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    col = '0;
    if (state_q == ST_SCAN || state_q == ST_DEBOUNCE || state_q == ST_PRESSED) begin
      col            = '1;
      col[col_idx_q] = 1'b0;
    end
  end

  assign key_down = (state_q == ST_PRESSED);
  assign ev_code  = KW'(int'(col_idx_q) * ROWS + int'(row_idx_q));

  // A full register keeps its data; the newer event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_rep   <= 1'b0;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      multi_err <= multi_hit;
      overrun   <= ev_fire && key_valid && !key_ready;
      if (ev_fire && (!key_valid || key_ready)) begin
        key_code  <= ev_code;
        key_rep   <= ev_rep;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: keypad matrix model, tick-level
// event prediction, and a monitor that checks every accepted event.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int TDIV  = 4;
  localparam int DEB   = 2;
  localparam int RDLY  = 6;
  localparam int RRATE = 3;

  typedef struct packed {
    logic [3:0] code;
    logic       rep;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col, key_code;
  logic       key_rep, key_valid, key_ready, key_down, multi_err, overrun;

  logic       keys [COLS][ROWS];
  logic [3:0] legend_tab [16] = '{4'h1, 4'h4, 4'h7, 4'hE, 4'h2, 4'h5, 4'h8, 4'h0,
                                  4'h3, 4'h6, 4'h9, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD};

  ev_t exp_q[$];
  int  n_vec = 0, n_err = 0;
  int  n_multi = 0, n_ovr = 0, n_pop = 0;
  int  exp_multi = 0, exp_ovr = 0;
  int  ecnt = 0;
  int  rdy_mode = 0;
  int  wait_cnt = 0;

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TDIV), .DEBOUNCE(DEB),
    .REPEAT_DLY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_rep   (key_rep),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .multi_err (multi_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[c][r] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt = 0;
    else        ecnt = ecnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Consumer: random ready, forced high once an event has waited 3 cycles.
  initial begin
    key_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin
          if (key_valid) wait_cnt++;
          else wait_cnt = 0;
          key_ready = (wait_cnt >= 3) || ($urandom_range(0, 2) != 0);
        end
        1:       key_ready = 1'b0;
        default: key_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (multi_err) n_multi++;
      if (overrun) n_ovr++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got code %0d rep %0d, required no event", key_code, key_rep);
        end else begin
          e = exp_q.pop_front();
          check("event_code", key_code, e.code);
          check("event_rep", key_rep, e.rep);
          check("event_legend", key_legend(key_code), legend_tab[e.code]);
        end
        n_pop++;
      end
    end
  end

  // Returns #1 after the next clock edge on which the DUT consumes a tick.
  task automatic wait_tick();
    do begin
      @(posedge clk);
      #1;
    end while (ecnt % TDIV != 0);
  endtask

  function automatic bit is_rep(input int k);
    if (RDLY == 0) return 1'b0;
    if (k == RDLY) return 1'b1;
    return (k > RDLY) && (RRATE > 0) && ((k - RDLY) % RRATE == 0);
  endfunction

  // Press key (c,r) right after a tick so it is first seen on the next tick,
  // hold it for L ticks. Scan reaches column c on tick 2+c, debounce ends on
  // tick e = 1+c+DEB, and every later held tick k counts toward auto-repeat.
  task automatic press_single(input int c, input int r, input int len, input bit stall);
    int   e, nev;
    ev_t  ev;
    wait_tick();
    e   = 1 + c + DEB;
    nev = 0;
    ev.code = 4'(c * ROWS + r);
    if (len >= e) begin
      ev.rep = 1'b0;
      exp_q.push_back(ev);
      nev = 1;
      for (int k = 1; k <= len - e; k++) begin
        if (is_rep(k)) begin
          if (!stall) begin
            ev.rep = 1'b1;
            exp_q.push_back(ev);
          end
          nev++;
        end
      end
      if (stall) exp_ovr += nev - 1;
    end
    keys[c][r] = 1'b1;
    for (int t = 1; t <= len; t++) begin
      wait_tick();
      if (len >= e && t == e - 1) begin
        check("pre_debounce_key_down", key_down, 0);
        check("pre_debounce_valid", key_valid, 0);
      end
      if (len >= e && t == e) begin
        check("press_key_down", key_down, 1);
        check("press_valid", key_valid, 1);
        check("press_col", col, 4'hF & ~(4'h1 << c));
      end
    end
    keys[c][r] = 1'b0;
    repeat (8) wait_tick();
    check("settled_key_down", key_down, 0);
    check("settled_col", col, 0);
  endtask

  task automatic press_multi(input int c, input int r1, input int r2, input int len);
    wait_tick();
    exp_multi++;
    keys[c][r1] = 1'b1;
    keys[c][r2] = 1'b1;
    for (int t = 1; t <= len; t++) begin
      wait_tick();
      if (t == 2 + c) begin
        check("multi_err_pulse", multi_err, 1);
        check("multi_col_release", col, 0);
        check("multi_no_valid", key_valid, 0);
      end
    end
    keys[c][r1] = 1'b0;
    keys[c][r2] = 1'b0;
    repeat (8) wait_tick();
    check("multi_settled_col", col, 0);
  endtask

  initial begin
    int ovr0, pop0, c, r, r2, kind;
    for (int i = 0; i < COLS; i++)
      for (int j = 0; j < ROWS; j++) keys[i][j] = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_col", col, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_rep", key_rep, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_down", key_down, 0);
    check("rst_multi_err", multi_err, 0);
    check("rst_overrun", overrun, 0);
    #11 rst_n = 1'b1;

    // Key "6" at column 2 row 1 held long enough for repeats at 6, 9, 12.
    press_single(2, 1, 1 + 2 + DEB + 14, 1'b0);
    // One-tick glitch: scan runs out and returns to idle with no event.
    press_single(1, 2, 1, 1'b0);
    check("glitch_queue_empty", exp_q.size(), 0);
    // row = 4'b1001 on column 1.
    press_multi(1, 1, 2, 6);

    // Consumer stalled across an initial event and one repeat.
    rdy_mode = 1;
    ovr0 = n_ovr;
    press_single(0, 3, 1 + 0 + DEB + RDLY, 1'b1);
    check("stall_valid_held", key_valid, 1);
    check("stall_code_kept", key_code, 3);
    check("stall_rep_kept", key_rep, 0);
    check("stall_overrun_once", n_ovr - ovr0, 1);
    pop0 = n_pop;
    rdy_mode = 2;
    for (int i = 0; i < 20 && n_pop == pop0; i++) begin
      @(negedge clk);
      #1;
    end
    check("stall_accept_seen", n_pop - pop0, 1);
    @(posedge clk);
    #1;
    check("valid_falls_after_accept", key_valid, 0);
    rdy_mode = 0;

    // Asynchronous reset while debouncing key (2,1).
    wait_tick();
    keys[2][1] = 1'b1;
    for (int t = 1; t <= 4; t++) wait_tick();
    check("debounce_col", col, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_col", col, 0);
    check("async_rst_key_down", key_down, 0);
    check("async_rst_valid", key_valid, 0);
    check("async_rst_code", key_code, 0);
    check("async_rst_rep", key_rep, 0);
    check("async_rst_multi", multi_err, 0);
    check("async_rst_overrun", overrun, 0);
    keys[2][1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    press_single(3, 0, 1 + 3 + DEB + 2, 1'b0);

    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 3);
      c    = $urandom_range(0, COLS - 1);
      r    = $urandom_range(0, ROWS - 1);
      if (kind == 0) begin
        r2 = (r + $urandom_range(1, ROWS - 1)) % ROWS;
        press_multi(c, r, r2, 2 + c + $urandom_range(0, 3));
      end else begin
        press_single(c, r, $urandom_range(1, 1 + c + DEB + 14), 1'b0);
      end
    end

    repeat (20) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("multi_err_total", n_multi, exp_multi);
    check("overrun_total", n_ovr, exp_ovr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner, the next generation of the team's 4x4 keypad front end. Drives active-low column strobes and samples active-low row returns. Debounces both press and release, rejects multi-key presses, and generates auto-repeat. Delivers each key event through a valid/ready holding register to the downstream consumer (display/command logic).

## Interface
Parameters:
- ROWS, 4, number of row inputs
- COLS, 4, number of column outputs
- TICK_DIV, 50000, clk cycles per scan tick (1 ms at 50 MHz); must be ≥2
- DEBOUNCE, 4, consecutive stable ticks required for press and for release
- REPEAT_DLY, 500, ticks held before the first repeat event; 0 disables repeat
- REPEAT_RATE, 100, ticks between repeat events

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- row  in  ROWS  keypad rows, active-low, asynchronous to clk
- col  out  COLS  column strobes, active-low
- key_code  out  KW=$clog2(ROWS*COLS)  key index = col_idx*ROWS + row_idx
- key_rep  out  1  1 = event is an auto-repeat
- key_valid  out  1  event available; held until accepted
- key_ready  in  1  consumer accepts when key_valid && key_ready
- key_down  out  1  a debounced key is currently held
- multi_err  out  1  one-cycle pulse: multi-key press rejected
- overrun  out  1  one-cycle pulse: event dropped while the holding register was full

## Operation
- row passes through a 2-flop synchronizer. All logic below uses the synchronized value and advances only on tick.
- tick is a 1-cycle pulse when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
- FSM states: IDLE, SCAN, DEBOUNCE, PRESSED, RELEASE.
- IDLE: col = all 0. If row != all 1 → SCAN with col_idx = 0.
- SCAN: drive only column col_idx low. Sample row on the next tick, giving one full tick of settling.
  - Exactly one row low → latch row_idx; enter DEBOUNCE with count 1.
  - More than one row low → multi_err pulse, enter RELEASE.
  - No row low → col_idx+1. After COLS-1, return to IDLE (treated as bounce).
- DEBOUNCE: hold the same column.
  - Same single-row pattern → count+1. At count == DEBOUNCE → emit event (key_rep = 0), key_down = 1, enter PRESSED.
  - Any other pattern → multi_err if more than one row is low, then RELEASE.
- PRESSED: hold the column.
  - Pattern unchanged → hold counter increments. Emit a repeat event (key_rep = 1) at REPEAT_DLY ticks, then every REPEAT_RATE ticks.
  - Pattern changed (released or additional key) → RELEASE.
- RELEASE: col = all 0, key_down = 0 on entry. Require row == all 1 for DEBOUNCE consecutive ticks, then IDLE. Any low row restarts the count.
- Holding register:
  - Event with key_valid = 0, or with a same-cycle accept → load key_code/key_rep, key_valid = 1.
  - Event with key_valid = 1 and key_ready = 0 → event dropped, overrun pulse. Held data is unchanged.
- Repeat counters saturate and never wrap.

## Timing
- Reset values: col = all 0, key_code = 0, key_rep = 0, key_valid = 0, key_down = 0, multi_err = 0, overrun = 0. FSM = IDLE, prescaler = 0.
- Reset assertion mid-operation clears all state immediately, without waiting for a clock edge.
- key_valid and key_down rise 1 clk after the tick on which debounce completes.
- Press-to-valid worst case: (1 + COLS + DEBOUNCE) ticks + 3 clk.
- key_valid falls 1 clk after the accepting edge.
- multi_err and overrun are registered pulses, 1 clk after the detecting tick.

## Structure
- Package keypad_pkg holds:
  - the state enum;
  - the KW width function;
  - key_legend(code), a 4x4 hex legend. Column 0: 1,4,7,E; column 1: 2,5,8,0; column 2: 3,6,9,F; column 3: A,B,C,D.
- Sub-module keypad_tick_gen: the prescaler, parameter TICK_DIV, output tick.

## Test plan
Configuration for all scenarios: ROWS = COLS = 4, TICK_DIV = 4, DEBOUNCE = 2, REPEAT_DLY = 6, REPEAT_RATE = 3.
- Hold the key at column 2, row 1 (row = 4'b1101 while col[2] is low):
  - Required: key_code = 9, key_legend = 6, key_rep = 0, key_valid held until key_ready, key_down = 1.
  - After release, key_down = 0 and IDLE is reached after 2 idle ticks.
- 1-tick row glitch → no key_valid; FSM returns to IDLE; col = 4'b0000.
- row = 4'b1001 on column 1 → multi_err pulses once; no key_valid; RELEASE until row = 4'hF for 2 ticks.
- Hold a key for 15 ticks after PRESSED → one initial event, then repeats at ticks 6, 9 and 12, each with key_rep = 1.
- key_ready held 0 across two events → first key_code retained, overrun pulses once; accepting then drops key_valid.
- rst_n driven low during DEBOUNCE, between clock edges → all outputs at reset values before the next clk edge; scanning resumes from IDLE after release.
